// File: rtl/lifo_ext_pkg.sv
// lifo_ext_pkg: read-mode names, per-cycle operation encoding and the
// occupancy-counter sizing helper shared by the LIFO files.
package lifo_ext_pkg;

  localparam string FWFT_TRUE  = "TRUE";
  localparam string FWFT_FALSE = "FALSE";

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_FLUSH
  } lifo_op_e;

  // Occupancy runs 0..DEPTH inclusive, so it needs one more code than DEPTH entries.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_ext_mem.sv
// lifo_ext_mem: DEPTH x DATA_W register array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module lifo_ext_mem
  import lifo_ext_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     w_idx,
  input  logic [DATA_W-1:0] w_data,
  input  logic [AW-1:0]     r_idx,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when the controller enables it.
  always_ff @(posedge clk) begin
    if (we) mem[w_idx] <= w_data;
  end

  assign r_data = mem[r_idx];

endmodule

// File: rtl/lifo_ext.sv
// lifo_ext: parameterised LIFO stack with push, pop, replace-top and flush,
// occupancy count, empty/full/almost flags and optional sticky error flags.
// Define LIFO_EXT_ERR_FLAGS_EN to enable ovf/udf; otherwise they read 0.
module lifo_ext
  import lifo_ext_pkg::*;
#(
  parameter string FWFT_MODE = FWFT_TRUE,
  parameter int    DEPTH     = 8,
  parameter int    DATA_W    = 16,
  parameter int    AE_LEVEL  = 1,
  parameter int    AF_LEVEL  = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        flush,
  input  logic                        w_req,
  input  logic [DATA_W-1:0]           w_data,
  input  logic                        r_req,
  output logic [DATA_W-1:0]           r_data,
  output logic [cnt_width(DEPTH)-1:0] cnt,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic                        ovf,
  output logic                        udf,
  input  logic                        err_clr
);

  localparam int CW = cnt_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  lifo_op_e          op;
  logic              ovf_evt;
  logic              udf_evt;
  logic [CW-1:0]     cnt_m1;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     push_idx;
  logic              mem_we;
  logic [AW-1:0]     mem_w_idx;
  logic [AW-1:0]     mem_r_idx;
  logic [DATA_W-1:0] mem_rd;

  // All flags come straight from the registered count.
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_empty = (cnt <= AE_C);
  assign almost_full  = (cnt >= AF_C);

  // The top entry sits one below the count; a fresh push lands at the count.
  assign cnt_m1   = cnt - CW'(1);
  assign top_idx  = cnt_m1[AW-1:0];
  assign push_idx = cnt[AW-1:0];

  // Decode the requests into one operation; flush overrides everything, and a
  // push+pop on an empty stack degrades to a plain push plus an underflow.
  always_comb begin
    op      = OP_IDLE;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (flush) begin
      op = OP_FLUSH;
    end else if (w_req && r_req) begin
      if (empty) begin
        op      = OP_PUSH;
        udf_evt = 1'b1;
      end else begin
        op = OP_REPLACE;
      end
    end else if (w_req) begin
      if (full) ovf_evt = 1'b1;
      else      op      = OP_PUSH;
    end else if (r_req) begin
      if (empty) udf_evt = 1'b1;
      else       op      = OP_POP;
    end
  end

  assign mem_we    = (op == OP_PUSH) || (op == OP_REPLACE);
  assign mem_w_idx = (op == OP_REPLACE) ? top_idx : push_idx;
  assign mem_r_idx = empty ? '0 : top_idx;

  lifo_ext_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .w_idx  (mem_w_idx),
    .w_data (w_data),
    .r_idx  (mem_r_idx),
    .r_data (mem_rd)
  );

  // Occupancy: cleared by flush, +1 on push, -1 on pop, unchanged on replace.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else begin
      case (op)
        OP_FLUSH: cnt <= '0;
        OP_PUSH:  cnt <= cnt + CW'(1);
        OP_POP:   cnt <= cnt_m1;
        default:  cnt <= cnt;
      endcase
    end
  end

  generate
    if (FWFT_MODE == FWFT_FALSE) begin : g_reg_read
      logic [DATA_W-1:0] r_data_q;

      // Capture the outgoing top on the edge that accepts a pop or replace.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_data_q <= '0;
        else if ((op == OP_POP) || (op == OP_REPLACE)) r_data_q <= mem_rd;
      end

      assign r_data = r_data_q;
    end else begin : g_fwft_read
      logic [DATA_W-1:0] hold_q;

      // Remember the last top shown so it can still be presented once empty.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) hold_q <= '0;
        else if (!empty) hold_q <= mem_rd;
      end

      assign r_data = empty ? hold_q : mem_rd;
    end
  endgenerate

`ifdef LIFO_EXT_ERR_FLAGS_EN
  // Sticky error flags: a new error wins over err_clr, and flush leaves them alone.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_evt | (ovf & ~err_clr);
      udf <= udf_evt | (udf & ~err_clr);
    end
  end
`else
  logic unused_err;

  assign ovf        = 1'b0;
  assign udf        = 1'b0;
  assign unused_err = &{1'b0, err_clr, ovf_evt, udf_evt};
`endif

endmodule

// File: tb/tb_lifo_ext.sv
// tb_lifo_ext: directed scoreboard bench for lifo_ext (DEPTH=8, DATA_W=16).
// One instance registers r_data on pop, a second shows the top first-word-fall-through.
module tb_lifo_ext;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
`ifdef LIFO_EXT_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic              clk     = 1'b0;
  logic              nrst    = 1'b0;
  logic              flush   = 1'b0;
  logic              w_req   = 1'b0;
  logic              r_req   = 1'b0;
  logic              err_clr = 1'b0;
  logic [DATA_W-1:0] w_data  = '0;

  logic [DATA_W-1:0] r_data_r, r_data_f;
  logic [3:0]        cnt_r, cnt_f;
  logic              empty_r, full_r, ae_r, af_r, ovf_r, udf_r;
  logic              empty_f, full_f, ae_f, af_f, ovf_f, udf_f;

  logic              rd_expect = 1'b0;
  logic              rd_fire;
  logic [DATA_W-1:0] exp_q[$];
  int                n_vec = 0;
  int                n_bad = 0;

  lifo_ext #(
    .FWFT_MODE ("FALSE"),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W)
  ) dut_r (
    .clk          (clk),
    .nrst         (nrst),
    .flush        (flush),
    .w_req        (w_req),
    .w_data       (w_data),
    .r_req        (r_req),
    .r_data       (r_data_r),
    .cnt          (cnt_r),
    .empty        (empty_r),
    .full         (full_r),
    .almost_empty (ae_r),
    .almost_full  (af_r),
    .ovf          (ovf_r),
    .udf          (udf_r),
    .err_clr      (err_clr)
  );

  lifo_ext #(
    .FWFT_MODE ("TRUE"),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W)
  ) dut_f (
    .clk          (clk),
    .nrst         (nrst),
    .flush        (flush),
    .w_req        (w_req),
    .w_data       (w_data),
    .r_req        (r_req),
    .r_data       (r_data_f),
    .cnt          (cnt_f),
    .empty        (empty_f),
    .full         (full_f),
    .almost_empty (ae_f),
    .almost_full  (af_f),
    .ovf          (ovf_f),
    .udf          (udf_f),
    .err_clr      (err_clr)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkStatus(input string name, input logic [3:0] c, input logic e, input logic f,
                             input logic ae, input logic af);
    checkOutput({name, "_cnt"}, cnt_r, c);
    checkOutput({name, "_empty"}, empty_r, e);
    checkOutput({name, "_full"}, full_r, f);
    checkOutput({name, "_ae"}, ae_r, ae);
    checkOutput({name, "_af"}, af_r, af);
  endtask

  // Drive one cycle of requests from a falling edge; a pop the bench expects to be
  // accepted queues its hand-computed data for the monitor.
  task automatic applyStimulus(input logic w, input logic [DATA_W-1:0] wd, input logic r,
                               input logic fl, input logic ec, input logic exp_rd,
                               input logic [DATA_W-1:0] exp_val);
    w_req     = w;
    w_data    = wd;
    r_req     = r;
    flush     = fl;
    err_clr   = ec;
    rd_expect = exp_rd;
    if (exp_rd) exp_q.push_back(exp_val);
    @(negedge clk);
    w_req     = 1'b0;
    r_req     = 1'b0;
    flush     = 1'b0;
    err_clr   = 1'b0;
    rd_expect = 1'b0;
  endtask

  // Mark the cycle after an expected pop edge as carrying registered read data.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) rd_fire <= 1'b0;
    else       rd_fire <= rd_expect;
  end

  // Monitor: pop the scoreboard and compare whenever read data is presented.
  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("[TB] FAIL pop_data: got 0x%0h, expected nothing (scoreboard empty)", r_data_r);
      end else begin
        checkOutput("pop_data", r_data_r, exp_q.pop_front());
      end
    end
  end

  // Hard bound on the run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] lifo_ext directed run, ERR_EN=%0d", ERR_EN);
    repeat (2) @(negedge clk);
    checkStatus("rst", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_rdata_r", r_data_r, 32'h0);
    checkOutput("rst_rdata_f", r_data_f, 32'h0);
    checkOutput("rst_ovf", ovf_r, 32'h0);
    checkOutput("rst_udf", udf_r, 32'h0);
    nrst = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      if (i == 7) checkStatus("push7", 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkStatus("push8", 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("fwft_top8", r_data_f, 32'h0008);

    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkStatus("ovf_push", 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("fwft_top_ovf", r_data_f, 32'h0008);
    checkOutput("ovf_set", ovf_r, {31'b0, ERR_EN});
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("ovf_clr", ovf_r, 32'h0);

    for (int i = 8; i >= 1; i--) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'(i));
    checkStatus("pop8", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("fwft_hold", r_data_f, 32'h0001);

    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    checkStatus("udf_pop", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("udf_rdata_hold", r_data_r, 32'h0001);
    checkOutput("udf_set", udf_r, {31'b0, ERR_EN});
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("udf_clr", udf_r, 32'h0);

    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003);
    checkStatus("replace", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00AA);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001);

    applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    checkStatus("push_on_empty", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("push_on_empty_rdata", r_data_r, 32'h0001);
    checkOutput("push_on_empty_udf", udf_r, {31'b0, ERR_EN});

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkStatus("pre_flush", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    checkStatus("flush", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_rdata_r", r_data_r, 32'h0001);
    checkOutput("flush_rdata_f", r_data_f, 32'h0013);
    checkOutput("flush_keeps_udf", udf_r, {31'b0, ERR_EN});

    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("clr_loses_udf", udf_r, {31'b0, ERR_EN});
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("udf_clr2", udf_r, 32'h0);

    applyStimulus(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0077);
    applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 16'h0031, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkStatus("pre_rst", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    w_req  = 1'b1;
    w_data = 16'h0032;
    #2 nrst = 1'b0;
    #1;
    checkStatus("async_rst", 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("async_rst_rdata_r", r_data_r, 32'h0);
    checkOutput("async_rst_rdata_f", r_data_f, 32'h0);
    @(negedge clk);
    w_data = 16'h1234;
    nrst   = 1'b1;
    @(negedge clk);
    w_req  = 1'b0;
    checkStatus("post_rst", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("fwft_show", r_data_f, 32'h1234);
    checkOutput("fwft_ae", ae_f, 32'h1);
    checkOutput("post_rst_rdata_r", r_data_r, 32'h0);

    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkStatus("ae_off", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
